// File: rtl/hyperram_pkg.sv
// hyperram_pkg: shared types and command/address packing for the HyperBus
// transaction sequencer (hyperram_seq).
package hyperram_pkg;

   // Sequencer states, in the order a transaction walks through them.
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CS_SETUP,
      ST_CA0,
      ST_CA1,
      ST_CA2,
      ST_LATENCY,
      ST_WR_DATA,
      ST_RD_DATA,
      ST_CS_HOLD,
      ST_RECOVER
   } state_t;

   // Command/address word layout (48 bits, sent MSB half-word first).
   localparam int CA_W       = 48;
   localparam int CA_RW_BIT  = 47;  // 1 = read
   localparam int CA_AS_BIT  = 46;  // 0 = memory space
   localparam int CA_BT_BIT  = 45;  // 1 = linear burst
   localparam int CA_ROW_MSB = 44;  // upper word-address bits
   localparam int CA_ROW_LSB = 16;
   localparam int CA_COL_MSB = 2;   // lower word-address bits

   // Build the 48-bit CA word from a request.
   function automatic logic [CA_W-1:0] ca_pack(input logic we, input logic [31:0] addr);
      logic [CA_W-1:0] ca;
      ca                        = '0;
      ca[CA_RW_BIT]             = ~we;
      ca[CA_AS_BIT]             = 1'b0;
      ca[CA_BT_BIT]             = 1'b1;
      ca[CA_ROW_MSB:CA_ROW_LSB] = addr[31:3];
      ca[CA_COL_MSB:0]          = addr[2:0];
      return ca;
   endfunction

endpackage

// File: rtl/hyperram_seq.sv
// hyperram_seq: HyperBus transaction sequencer on clk0. Takes read/write
// burst requests and drives the DDR iobuf (csn, CK enable, data, RWDS).
// Optional read watchdog: define HYPERRAM_SEQ_RD_TIMEOUT_EN.
module hyperram_seq
   import hyperram_pkg::*;
#(
   parameter int MAX_BURST  = 64,
   parameter int LAT_CYCLES = 6,
   parameter int FIXED_LAT  = 1,
   parameter int TRWR       = 3,
   parameter int RD_TIMEOUT = 64
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_we,
   input  logic [31:0]                  req_addr,
   input  logic [$clog2(MAX_BURST)-1:0] req_len,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [15:0]                  wr_data,
   input  logic [1:0]                   wr_mask,
   output logic                         rd_valid,
   output logic [15:0]                  rd_data,
   output logic                         rd_last,
   output logic                         done,
   output logic                         err,
   output logic                         csn,
   output logic                         oe_clk,
   output logic                         oe_data,
   output logic [15:0]                  datain,
   input  logic [15:0]                  dataout,
   input  logic                         rwds_in,
   output logic [1:0]                   rwds_out,
   output logic                         rwds_oe
);

   localparam int LEN_W   = $clog2(MAX_BURST);
   // One width covers every cycle count the sequencer ever loads.
   localparam int CNT_MAX = (2*LAT_CYCLES > MAX_BURST) ?
                            ((2*LAT_CYCLES > RD_TIMEOUT) ? 2*LAT_CYCLES : RD_TIMEOUT) :
                            ((MAX_BURST > RD_TIMEOUT) ? MAX_BURST : RD_TIMEOUT);
   localparam int CNT_W   = $clog2(((CNT_MAX > TRWR) ? CNT_MAX : TRWR) + 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_we;
   logic [31:0]        r_addr;
   logic [LEN_W-1:0]   r_len;
   logic               r_mult2;
   logic [CNT_W-1:0]   r_cnt;
   logic [CA_W-1:0]    w_ca;
   logic               w_cnt_zero;
   logic               w_timeout;

   assign w_ca       = ca_pack(r_we, r_addr);
   assign w_cnt_zero = (r_cnt == '0);

`ifdef HYPERRAM_SEQ_RD_TIMEOUT_EN
   logic [CNT_W-1:0] r_wdog;

   // Cycles since the last valid read word; cleared outside RD_DATA.
   always_ff @(posedge clk) begin
      if (!rstn || r_state != ST_RD_DATA || rwds_in)
         r_wdog <= '0;
      else
         r_wdog <= r_wdog + CNT_W'(1);
   end

   assign w_timeout = (r_state == ST_RD_DATA) && !rwds_in &&
                      (r_wdog == CNT_W'(RD_TIMEOUT - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // State register; reset aborts any burst straight back to IDLE.
   always_ff @(posedge clk) begin
      if (!rstn)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Request capture on accept and latency multiplier sampled in CA0.
   always_ff @(posedge clk) begin
      if (r_state == ST_IDLE && req_valid) begin
         r_we   <= req_we;
         r_addr <= req_addr;
         r_len  <= req_len;
      end
      if (r_state == ST_CA0)
         r_mult2 <= (FIXED_LAT != 0) || rwds_in;
   end

   // Shared down-counter: latency cycles, then words left, then recovery.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else begin
         case (r_state)
            ST_CA2:     r_cnt <= r_mult2 ? CNT_W'(2*LAT_CYCLES - 1) : CNT_W'(LAT_CYCLES - 1);
            ST_LATENCY: r_cnt <= w_cnt_zero ? CNT_W'(r_len) : r_cnt - CNT_W'(1);
            ST_WR_DATA: if (wr_valid && !w_cnt_zero) r_cnt <= r_cnt - CNT_W'(1);
            ST_RD_DATA: if (rwds_in && !w_cnt_zero) r_cnt <= r_cnt - CNT_W'(1);
            ST_CS_HOLD: r_cnt <= CNT_W'(TRWR - 1);
            ST_RECOVER: if (!w_cnt_zero) r_cnt <= r_cnt - CNT_W'(1);
            default:    r_cnt <= r_cnt;
         endcase
      end
   end

   // Next state and all iobuf/user outputs decoded from the current state.
   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      csn         = 1'b1;
      oe_clk      = 1'b0;
      oe_data     = 1'b0;
      datain      = '0;
      rwds_out    = '0;
      rwds_oe     = 1'b0;
      wr_ready    = 1'b0;
      rd_valid    = 1'b0;
      rd_data     = '0;
      rd_last     = 1'b0;
      done        = 1'b0;
      err         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            req_ready = rstn;
            if (req_valid && rstn) w_state_nxt = ST_CS_SETUP;
         end
         ST_CS_SETUP: begin
            csn         = 1'b0;
            w_state_nxt = ST_CA0;
         end
         ST_CA0: begin
            csn         = 1'b0;
            oe_clk      = 1'b1;
            oe_data     = 1'b1;
            datain      = w_ca[47:32];
            w_state_nxt = ST_CA1;
         end
         ST_CA1: begin
            csn         = 1'b0;
            oe_clk      = 1'b1;
            oe_data     = 1'b1;
            datain      = w_ca[31:16];
            w_state_nxt = ST_CA2;
         end
         ST_CA2: begin
            csn         = 1'b0;
            oe_clk      = 1'b1;
            oe_data     = 1'b1;
            datain      = w_ca[15:0];
            w_state_nxt = ST_LATENCY;
         end
         ST_LATENCY: begin
            csn    = 1'b0;
            oe_clk = 1'b1;
            if (w_cnt_zero) w_state_nxt = r_we ? ST_WR_DATA : ST_RD_DATA;
         end
         ST_WR_DATA: begin
            // CK stops while the user stalls, so the memory sees no gap.
            csn      = 1'b0;
            wr_ready = 1'b1;
            oe_data  = 1'b1;
            rwds_oe  = 1'b1;
            datain   = wr_data;
            rwds_out = wr_mask;
            oe_clk   = wr_valid;
            if (wr_valid && w_cnt_zero) w_state_nxt = ST_CS_HOLD;
         end
         ST_RD_DATA: begin
            csn      = 1'b0;
            oe_clk   = 1'b1;
            rd_valid = rwds_in;
            rd_data  = dataout;
            rd_last  = rwds_in && w_cnt_zero;
            if (rwds_in && w_cnt_zero) begin
               w_state_nxt = ST_CS_HOLD;
            end else if (w_timeout) begin
               err         = 1'b1;
               w_state_nxt = ST_CS_HOLD;
            end
         end
         ST_CS_HOLD: begin
            csn         = 1'b0;
            w_state_nxt = ST_RECOVER;
         end
         ST_RECOVER: begin
            done = (r_cnt == CNT_W'(TRWR - 1));
            if (w_cnt_zero) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule
